// File: rtl/sw_debounce_sync.sv
// Switch/button conditioner: 2-flop sync plus counter debounce per bit.
// Optional SW_DEBOUNCE_CHANGE_LATCH_EN adds sticky change flags (chg_clr/chg_flag).
module sw_debounce_sync #(
  parameter int unsigned WIDTH           = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter bit          RESET_LEVEL     = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
`ifdef SW_DEBOUNCE_CHANGE_LATCH_EN
  ,
  input  logic [WIDTH-1:0] chg_clr,
  output logic [WIDTH-1:0] chg_flag
`endif
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [CW-1:0]    cnt [WIDTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= {WIDTH{RESET_LEVEL}};
      sync2 <= {WIDTH{RESET_LEVEL}};
    end else begin
      sync1 <= sw_raw;
      sync2 <= sync1;
    end
  end

  // Counter only advances while sync2 disagrees with the stable level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_out     <= {WIDTH{RESET_LEVEL}};
      rise_pulse <= '0;
      fall_pulse <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        rise_pulse[i] <= 1'b0;
        fall_pulse[i] <= 1'b0;
        if (sync2[i] == sw_out[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == LAST) begin
          sw_out[i]     <= sync2[i];
          cnt[i]        <= '0;
          rise_pulse[i] <= sync2[i];
          fall_pulse[i] <= ~sync2[i];
        end else begin
          cnt[i] <= cnt[i] + ONE;
        end
      end
    end
  end

`ifdef SW_DEBOUNCE_CHANGE_LATCH_EN
  // A pulse in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chg_flag <= '0;
    end else begin
      chg_flag <= (chg_flag & ~chg_clr) | rise_pulse | fall_pulse;
    end
  end
`endif

endmodule

// File: tb/tb_sw_debounce_sync.sv
// Scoreboard bench for sw_debounce_sync (WIDTH=2, DEBOUNCE_CYCLES=4).
// Reference model: output follows once sync2 has differed for DC edges.
module tb_sw_debounce_sync;

  localparam int W  = 2;
  localparam int DC = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] sw_raw = 2'b11;
  logic [W-1:0] sw_out;
  logic [W-1:0] rise_pulse;
  logic [W-1:0] fall_pulse;
`ifdef SW_DEBOUNCE_CHANGE_LATCH_EN
  logic [W-1:0] chg_clr = '0;
  logic [W-1:0] chg_flag;
`endif

  sw_debounce_sync #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(DC),
    .RESET_LEVEL(1'b0)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .sw_raw(sw_raw),
    .sw_out(sw_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse)
`ifdef SW_DEBOUNCE_CHANGE_LATCH_EN
    ,
    .chg_clr(chg_clr),
    .chg_flag(chg_flag)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] o;
    logic [W-1:0] r;
    logic [W-1:0] f;
    logic [W-1:0] g;
  } exp_t;

  exp_t q[$];
  int compared = 0;
  int mismatched = 0;

  // Model state: raw samples indexed so that samp[e] is sync2 at edge e.
  logic [W-1:0] samp[$];
  logic [W-1:0] m_out, m_rise, m_fall, m_flag;
  logic [W-1:0] nr, nf;
  int last_chg[W];
  int k;
  bit ok;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_out  = '0;
      m_rise = '0;
      m_fall = '0;
      m_flag = '0;
      samp.delete();
      samp.push_back('0);
      samp.push_back('0);
      k = 0;
      for (int b = 0; b < W; b++) last_chg[b] = -1;
    end else begin
      nr = '0;
      nf = '0;
      for (int b = 0; b < W; b++) begin
        ok = (k - DC + 1 > last_chg[b]) && (k - DC + 1 >= 0);
        if (ok)
          for (int j = 0; j < DC; j++)
            if (samp[k-j][b] == m_out[b]) ok = 1'b0;
        if (ok) begin
          m_out[b]    = ~m_out[b];
          last_chg[b] = k;
          if (m_out[b]) nr[b] = 1'b1;
          else          nf[b] = 1'b1;
        end
      end
`ifdef SW_DEBOUNCE_CHANGE_LATCH_EN
      m_flag = (m_flag & ~chg_clr) | m_rise | m_fall;
`endif
      m_rise = nr;
      m_fall = nf;
      samp.push_back(sw_raw);
      k++;
    end
    q.push_back('{o: m_out, r: m_rise, f: m_fall, g: m_flag});
  end

  exp_t e;
  logic [W-1:0] act_g;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
`ifdef SW_DEBOUNCE_CHANGE_LATCH_EN
      act_g = chg_flag;
`else
      act_g = '0;
`endif
      compared++;
      if (sw_out !== e.o || rise_pulse !== e.r ||
          fall_pulse !== e.f || act_g !== e.g) begin
        mismatched++;
        $display("FAIL sb t=%0t: out=%b rise=%b fall=%b flag=%b want %b %b %b %b",
                 $time, sw_out, rise_pulse, fall_pulse, act_g,
                 e.o, e.r, e.f, e.g);
      end
    end
  end

  task automatic hold(input logic [W-1:0] v, input int n);
    @(negedge clk);
    #1;
    sw_raw = v;
`ifdef SW_DEBOUNCE_CHANGE_LATCH_EN
    chg_clr = W'($urandom);
`endif
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic do_reset(input logic [W-1:0] v, input int n);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    sw_raw  = v;
    repeat (n) @(negedge clk);
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #2;
    sw_raw  = 2'b00;
    reset_n = 1'b1;
    hold(2'b00, 6);
    hold(2'b01, 10);
    hold(2'b00, 3);
    hold(2'b01, 3);
    hold(2'b00, 10);
    hold(2'b01, 2);
    hold(2'b00, 2);
    hold(2'b01, 2);
    hold(2'b00, 2);
    hold(2'b01, 10);
    hold(2'b10, 10);
    hold(2'b00, 10);
    hold(2'b01, 4);
    do_reset(2'b01, 3);
    hold(2'b01, 10);
    do_reset(2'b11, 2);
    hold(2'b11, 9);
    hold(2'b00, 9);
    repeat (300) hold(W'($urandom), $urandom_range(1, 8));
    do_reset(W'($urandom), $urandom_range(1, 4));
    repeat (100) hold(W'($urandom), $urandom_range(1, 8));
    repeat (3) @(negedge clk);
    #3;
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: queue=%0d want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sw_debounce_sync.md
Name: sw_debounce_sync

Overview:
Conditions raw slide-switch/push-button inputs from the board pins before they reach the NIOS II PIO input port.
- Per bit: 2-flop synchronizer into the clock domain, then a counter-based debouncer.
- Outputs a stable level vector that drives the PIO in_port directly.
- Also outputs one-cycle rise/fall pulses for local logic.
- Sits between the top-level pin assignments and the PIO slave.

Parameters:
WIDTH, 1, number of independent switch bits.
DEBOUNCE_CYCLES, 50000, consecutive cycles the synchronized input must differ from sw_out before sw_out follows (1 ms at 50 MHz); legal range 1 to 2^24.
RESET_LEVEL, 0, 1-bit level loaded into every sync flop and every sw_out bit on reset.

Ports:
clk  input  1  system clock; single clock domain.
reset_n  input  1  asynchronous, active-low reset.
sw_raw  input  WIDTH  unsynchronized switch pins.
sw_out  output  WIDTH  debounced stable level; drives PIO in_port.
rise_pulse  output  WIDTH  1-cycle pulse when a sw_out bit goes 0->1.
fall_pulse  output  WIDTH  1-cycle pulse when a sw_out bit goes 1->0.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values while reset_n=0:
  - sync1, sync2, sw_out: all bits = RESET_LEVEL.
  - rise_pulse, fall_pulse: 0.
  - All counters: 0.
- Per-bit datapath: sw_raw[i] -> sync1[i] -> sync2[i]; no logic between the sync flops.
- Per-bit counter: width $clog2(DEBOUNCE_CYCLES+1), unsigned, never wraps.
- Each rising edge, per bit:
  - sync2 == sw_out: counter <= 0; pulses 0.
  - sync2 != sw_out and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - sync2 != sw_out and counter == DEBOUNCE_CYCLES-1:
    - sw_out <= sync2; counter <= 0.
    - rise_pulse or fall_pulse = 1 for exactly this one cycle, registered and coincident with the sw_out change.
- Latency: sw_out changes on the (DEBOUNCE_CYCLES+2)th rising edge, counting the first edge at which sync1 captures the new raw value.
- Glitch rejection: if sync2 returns to sw_out before the count completes, the counter clears and there is no output change or pulse.
- Bits are fully independent. Simultaneous changes on several bits produce pulses in the same cycle.
- rise_pulse[i] and fall_pulse[i] are never both 1.
- DEBOUNCE_CYCLES=1: the block behaves as a synchronizer plus one register stage (3-edge latency).
- Reset asserted mid-count: immediate return to reset values; no pulse on release.
- No spurious edge after reset when sw_raw equals RESET_LEVEL.
- All outputs are registered; no combinational path from sw_raw to any output.

Optional Feature:
SW_DEBOUNCE_CHANGE_LATCH_EN
- Defined: adds two ports.
  - chg_clr  input  WIDTH.
  - chg_flag  output  WIDTH, sticky, reset 0.
- chg_flag[i] sets on any rise_pulse[i] or fall_pulse[i].
- chg_flag[i] clears when chg_clr[i]=1 on a clock edge.
- Set in the same cycle as clear: set wins, so flag stays 1.
- Purpose: software can poll for missed toggles via a second PIO.
- Undefined: both ports and their logic are absent; the core debounce behaviour is identical.

Test Plan:
1. Bench parameters: WIDTH=2, DEBOUNCE_CYCLES=4, RESET_LEVEL=0.
   Hold reset_n=0 with sw_raw=2'b11, then release with sw_raw=2'b00 -> sw_out=00 throughout; no pulses; counters 0.
2. sw_raw[0] 0->1 before edge E0, then held -> sw_out[0]=1 after edge E5 (6th edge); rise_pulse[0]=1 for exactly that cycle; sw_out[1] stays 0.
3. sw_raw[0] high for 3 cycles, then low -> sw_out stays 00; no pulses.
4. Bounce on sw_raw[0]: 1,0,1,0 each for 2 cycles, then steady 1 -> exactly one rise_pulse[0], 6 edges after the final transition is sampled.
5. From sw_out=01, change sw_raw to 10 in one cycle -> fall_pulse[0] and rise_pulse[1] in the same cycle; sw_out=10.
6. Assert reset_n=0 when bit0 counter=2; release with sw_raw=01 held -> sw_out=00 during reset; one rise_pulse[0] occurs only after a full 6-edge count from release.
   With SW_DEBOUNCE_CHANGE_LATCH_EN defined, also check: chg_flag[0]=1 after the pulse; chg_clr[0] coincident with a new pulse leaves chg_flag[0]=1.
